// File: rtl/bitmap_enc_pkg.sv
// rtl/bitmap_enc_pkg.sv - shared state type and width helper for the bitmap encoder
package bitmap_enc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Bitmap width for an N-bit index.
   function automatic int W(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/bitmap_encoder_if.sv
// rtl/bitmap_encoder_if.sv - bitmap input and index output handshakes of the bitmap encoder
interface bitmap_encoder_if #(
   parameter int N = 3
);
   import bitmap_enc_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [W(N)-1:0] in_vec;

   logic            out_valid;
   logic            out_ready;
   logic [N-1:0]    out_idx;
   logic            out_last;
   logic            out_empty;
   logic            out_err;

   modport master (
      output in_valid,
      output in_vec,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_idx,
      input  out_last,
      input  out_empty,
      input  out_err
   );

   modport slave (
      input  in_valid,
      input  in_vec,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_idx,
      output out_last,
      output out_empty,
      output out_err
   );

endinterface

// File: rtl/lsb_priority_enc.sv
// rtl/lsb_priority_enc.sv - lowest-set-bit index of a 2**N-bit vector, N-level pairwise tree
module lsb_priority_enc
   import bitmap_enc_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [W(N)-1:0] vec,
   output logic [N-1:0]    idx,
   output logic            nonzero
);

   localparam int WV = W(N);

   logic [WV-1:0]         nz_a;
   logic [WV-1:0][N-1:0]  idx_a;

   // Each level merges node pairs in place: node n reads 2n/2n+1, which are
   // never overwritten before being read because n <= 2n.  The low child wins;
   // taking the high child sets the index bit owned by this level.
   always_comb begin
      nz_a  = vec;
      idx_a = '0;
      for (int l = 1; l <= N; l++) begin
         for (int n = 0; n < (WV >> l); n++) begin
            if (nz_a[2*n]) begin
               nz_a[n]  = 1'b1;
               idx_a[n] = idx_a[2*n];
            end else begin
               nz_a[n]         = nz_a[2*n+1];
               idx_a[n]        = idx_a[2*n+1];
               idx_a[n][l-1]   = 1'b1;
            end
         end
      end
      idx     = idx_a[0];
      nonzero = nz_a[0];
   end

endmodule

// File: rtl/bitmap_encoder.sv
// rtl/bitmap_encoder.sv - streams the index of every set bit of a bitmap, LSB first
// Optional: BITMAP_ENC_ONEHOT_CHECK_EN flags multi-hot bitmaps on out_err.
module bitmap_encoder
   import bitmap_enc_pkg::*;
#(
   parameter int N = 3
) (
   input logic             clk,
   input logic             rst_n,
   bitmap_encoder_if.slave bus
);

   localparam int WV = W(N);

   state_t          state_q, state_d;
   logic [WV-1:0]   pend_q, pend_d;
   logic            empty_q, empty_d;
   logic [WV-1:0]   pend_rest;
   logic [N-1:0]    enc_idx;
   logic            enc_nz;
   logic            drain;
   logic            beat_last;
   logic            beat_fire;
   logic            accept;

`ifdef BITMAP_ENC_ONEHOT_CHECK_EN
   logic            multi_q, multi_d;
`endif

   lsb_priority_enc #(.N(N)) u_enc (
      .vec     (pend_q),
      .idx     (enc_idx),
      .nonzero (enc_nz)
   );

   assign pend_rest = pend_q & (pend_q - 1'b1);
   assign drain     = (state_q == DRAIN);
   assign beat_last = empty_q || (pend_rest == '0);
   assign beat_fire = drain && bus.out_ready;
   assign accept    = bus.in_valid && bus.in_ready;

   // Beat fields come only from flops; in_ready alone looks at out_ready so a
   // new bitmap can be taken on the final beat without an idle bubble.
   assign bus.in_ready  = !drain || (bus.out_ready && beat_last);
   assign bus.out_valid = drain;
   assign bus.out_idx   = (drain && enc_nz) ? enc_idx : '0;
   assign bus.out_last  = drain && beat_last;
   assign bus.out_empty = drain && empty_q;
`ifdef BITMAP_ENC_ONEHOT_CHECK_EN
   assign bus.out_err   = drain && multi_q;
`else
   assign bus.out_err   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      empty_d = empty_q;
`ifdef BITMAP_ENC_ONEHOT_CHECK_EN
      multi_d = multi_q;
`endif
      if (beat_fire) begin
         pend_d = pend_rest;
         if (beat_last) begin
            state_d = IDLE;
         end
      end
      if (accept) begin
         state_d = DRAIN;
         pend_d  = bus.in_vec;
         empty_d = (bus.in_vec == '0);
`ifdef BITMAP_ENC_ONEHOT_CHECK_EN
         multi_d = |(bus.in_vec & (bus.in_vec - 1'b1));
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         empty_q <= 1'b0;
`ifdef BITMAP_ENC_ONEHOT_CHECK_EN
         multi_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         empty_q <= empty_d;
`ifdef BITMAP_ENC_ONEHOT_CHECK_EN
         multi_q <= multi_d;
`endif
      end
   end

endmodule
